// File: rtl/quadrature_decoder_if.sv
// Pin-side and control-side signals of the quadrature decoder, grouped for port hookup.
interface quadrature_decoder_if #(
  parameter int unsigned POS_W = 16,
  parameter int unsigned SPD_W = 16
);
  logic             enc_a;
  logic             enc_b;
  logic             clear_pos;
  logic             err_clr;
  logic [POS_W-1:0] position;
  logic             direction;
  logic [SPD_W-1:0] speed;
  logic             speed_valid;
  logic             moving;
  logic             quad_err;

  modport master (
    output enc_a, enc_b, clear_pos, err_clr,
    input  position, direction, speed, speed_valid, moving, quad_err
  );

  modport slave (
    input  enc_a, enc_b, clear_pos, err_clr,
    output position, direction, speed, speed_valid, moving, quad_err
  );
endinterface

// File: rtl/quadrature_decoder.sv
// Quadrature encoder decoder: synchronizer, per-channel glitch filter, step decode,
// signed position count, direction, sticky illegal-transition flag and windowed edge rate.
module quadrature_decoder #(
  parameter int unsigned FILTER_LEN    = 4,
  parameter int unsigned POS_W         = 16,
  parameter int unsigned SPD_W         = 16,
  parameter int unsigned WINDOW_CYCLES = 1000000
) (
  input logic                 clk,
  input logic                 rst,
  quadrature_decoder_if.slave bus
);
  localparam int unsigned WinW    = $clog2(WINDOW_CYCLES);
  localparam logic [3:0]  FiltMax = 4'(FILTER_LEN - 1);
  localparam logic [WinW-1:0] WinLast = WinW'(WINDOW_CYCLES - 1);

  typedef enum logic {StUnprimed, StPrimed} state_e;

  // Channel vectors: bit 1 = A, bit 0 = B
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      lvl_q, lvl_d, vld_q, vld_d;
  logic [1:0][3:0] cnt_q, cnt_d;
  state_e          state_q, state_d;
  logic [1:0]      ref_q, ref_d;
  logic            step_fwd, step_rev, step_bad;
  logic [1:0]      phase_diff;

  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d, err_q, err_d;
  logic [WinW-1:0]  win_q, win_d;
  logic [SPD_W-1:0] edge_q, edge_d, edge_sum, speed_q, speed_d;
  logic             moving_q, moving_d, sv_q, wrap;

  // Gray position of {a,b} in the forward sequence 00,10,11,01
  function automatic logic [1:0] phase(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

  // Until a channel has a trusted level, count consecutive equal samples;
  // afterwards, count consecutive samples that disagree with the level.
  always_comb begin
    lvl_d = lvl_q;
    vld_d = vld_q;
    cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (!vld_q[i]) begin
        if (sync2_q[i] != lvl_q[i]) begin
          lvl_d[i] = sync2_q[i];
          vld_d[i] = (FILTER_LEN == 1);
          cnt_d[i] = 4'd1;
        end else if (cnt_q[i] == FiltMax) begin
          vld_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end else if (sync2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == FiltMax) lvl_d[i] = sync2_q[i];
        else                     cnt_d[i] = cnt_q[i] + 4'd1;
      end
    end
  end

  assign phase_diff = phase(lvl_q) - phase(ref_q);

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    step_fwd = 1'b0;
    step_rev = 1'b0;
    step_bad = 1'b0;
    case (state_q)
      StUnprimed: begin
        if (&vld_q) begin
          state_d = StPrimed;
          ref_d   = lvl_q;
        end
      end
      StPrimed: begin
        ref_d = lvl_q;
        case (phase_diff)
          2'd1:    step_fwd = 1'b1;
          2'd2:    step_bad = 1'b1;
          2'd3:    step_rev = 1'b1;
          default: ;
        endcase
      end
    endcase
  end

  always_comb begin
    pos_d = pos_q;
    if (bus.clear_pos)  pos_d = '0;
    else if (step_fwd)  pos_d = pos_q + POS_W'(1);
    else if (step_rev)  pos_d = pos_q - POS_W'(1);
    dir_d    = step_fwd ? 1'b1 : (step_rev ? 1'b0 : dir_q);
    err_d    = step_bad | (err_q & ~bus.err_clr);
    wrap     = (win_q == WinLast);
    win_d    = wrap ? '0 : win_q + WinW'(1);
    edge_sum = edge_q + SPD_W'((step_fwd | step_rev) && (edge_q != '1));
    edge_d   = wrap ? '0 : edge_sum;
    speed_d  = wrap ? edge_sum : speed_q;
    moving_d = wrap ? (edge_sum != '0) : moving_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      lvl_q    <= '0;
      vld_q    <= '0;
      cnt_q    <= '0;
      state_q  <= StUnprimed;
      ref_q    <= '0;
      pos_q    <= '0;
      dir_q    <= 1'b1;
      err_q    <= 1'b0;
      win_q    <= '0;
      edge_q   <= '0;
      speed_q  <= '0;
      moving_q <= 1'b0;
      sv_q     <= 1'b0;
    end else begin
      sync1_q  <= {bus.enc_a, bus.enc_b};
      sync2_q  <= sync1_q;
      lvl_q    <= lvl_d;
      vld_q    <= vld_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      ref_q    <= ref_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
      win_q    <= win_d;
      edge_q   <= edge_d;
      speed_q  <= speed_d;
      moving_q <= moving_d;
      sv_q     <= wrap;
    end
  end

  assign bus.position    = pos_q;
  assign bus.direction   = dir_q;
  assign bus.quad_err    = err_q;
  assign bus.speed       = speed_q;
  assign bus.speed_valid = sv_q;
  assign bus.moving      = moving_q;
endmodule

// File: doc/quadrature_decoder.md
# quadrature_decoder

Decodes the two-channel quadrature encoder on the motor shaft into a signed position count, a direction flag and a per-window edge rate. It is the feedback path for the H-bridge direction/brake control. Its `direction` output uses the same polarity as that control's `direction` input: 1 means the motor turns the way INA=1/INB=0 drives it. The block sits between the encoder input pins and the speed/position control logic.

## Interface
Parameters:
- `FILTER_LEN`, default 4: consecutive equal synchronized samples needed before a channel's filtered level changes; range 1–15.
- `POS_W`, default 16: position counter width.
- `SPD_W`, default 16: speed (edges per window) width.
- `WINDOW_CYCLES`, default 1000000: clock cycles per speed window; must be ≥ 2.

Ports:
- `clk` input 1: single clock; all logic is on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `enc_a` input 1: encoder channel A, asynchronous to `clk`.
- `enc_b` input 1: encoder channel B, asynchronous to `clk`.
- `clear_pos` input 1: synchronous; sets `position` to 0.
- `err_clr` input 1: synchronous; clears `quad_err`.
- `position` output POS_W: two's-complement position count, wraps modulo 2^POS_W.
- `direction` output 1: direction of the last valid step; 1 = forward.
- `speed` output SPD_W: valid edges counted in the last completed window.
- `speed_valid` output 1: one-cycle pulse when `speed` updates.
- `moving` output 1: high when the last completed window contained at least one valid edge.
- `quad_err` output 1: sticky flag for an illegal transition.

## Operation
- **Synchronizer:** two flops per channel.
- **Filter:** one counter per channel. The filtered level takes the synchronized value after FILTER_LEN consecutive samples that differ from the current filtered level. A sample equal to the filtered level resets that channel's counter.
- **Priming:** after reset, the state is UNPRIMED. The first filtered AB value (FILTER_LEN stable samples on both channels) is loaded as the reference without counting, and the state becomes PRIMED.
- **Step decode** (previous filtered AB → current filtered AB):
  - Forward, +1, `direction`←1: 00→10, 10→11, 11→01, 01→00 (A leads B).
  - Reverse, −1, `direction`←0: the four opposite transitions.
  - Both bits changing in the same cycle is illegal: position and direction are unchanged, `quad_err`←1, and the reference still updates to the new AB.
  - No change: nothing happens.
- **Position:** `position` wraps from 2^(POS_W−1)−1 to −2^(POS_W−1) and back. If `clear_pos` and a step occur in the same cycle, the result is 0 (clear wins).
- **Error flag:** `quad_err` stays set until `err_clr`. If `err_clr` and a new illegal transition occur in the same cycle, `quad_err` stays 1.
- **Speed window:**
  - A window counter runs from 0 to WINDOW_CYCLES−1 and wraps.
  - The edge counter increments on every valid step in either direction and saturates at 2^SPD_W−1.
  - On the wrap cycle: `speed`←edge count, including any step in that same cycle; `speed_valid` pulses; `moving`←(count≠0); the edge counter restarts at 0.
  - `clear_pos` does not affect the speed logic.

## Timing
- **Reset values:** `position`=0, `direction`=1, `speed`=0, `speed_valid`=0, `moving`=0, `quad_err`=0. Filter and window counters are 0 and the state is UNPRIMED.
- **Step latency:** a channel level change that stays stable updates `position`/`direction` on the (FILTER_LEN+3)th rising edge. The edge that first captures the new level counts as edge 1.
- **Pulse filtering:** pulses shorter than FILTER_LEN cycles, after synchronization, produce no step.
- **Speed updates:** `speed` and `moving` update on the same edge that `speed_valid` is high. `speed_valid` is high for exactly one cycle every WINDOW_CYCLES cycles; the first pulse comes WINDOW_CYCLES cycles after reset deasserts.
- **Reset mid-operation:** asserting `rst` at any time forces all outputs to their reset values immediately. Re-priming then occurs with no spurious count.

## Test plan
- **Forward rotation:** after priming at AB=00, drive 00→10→11→01→00 three times, each level held 10 cycles, FILTER_LEN=4 → `position`=12, `direction`=1, `quad_err`=0.
- **Reverse and wrap:** from `position`=0, drive one reverse step → `position`=0xFFFF (POS_W=16), `direction`=0. A forward step then returns `position` to 0.
- **Glitch rejection:** 3-cycle pulses on `enc_a` → no change in position. A 4-cycle pulse produces +1 then −1.
- **Illegal transition:** jump 00→11 → `position` unchanged, `quad_err`=1 until `err_clr`. With `err_clr` and a second illegal jump in the same cycle → `quad_err` stays 1.
- **Speed window:** WINDOW_CYCLES=100 with 7 steps in a window → `speed`=7 with a one-cycle `speed_valid` and `moving`=1. The next window with no steps → `speed`=0, `moving`=0.
- **Clear and reset:** `clear_pos` coincident with a step → `position`=0. `rst` asserted while at AB=11 → all outputs take reset values, and after release the first AB value is loaded with `position` still 0.
